// File: rtl/demux1to4_buf_if.sv
// Handshake bundle for demux1to4_buf: one input stream, four buffered output channels (A..D).
// Optional DEMUX1TO4_COUNT_EN adds the per-channel drain counters o_count_A..o_count_D.
interface demux1to4_buf_if #(
    parameter int NB_DATA = 32
);
    logic [NB_DATA-1:0] i_data;
    logic [1:0]         i_sel;
    logic               i_valid;
    logic               o_ready;

    logic [NB_DATA-1:0] o_data_A, o_data_B, o_data_C, o_data_D;
    logic               o_valid_A, o_valid_B, o_valid_C, o_valid_D;
    logic               i_ready_A, i_ready_B, i_ready_C, i_ready_D;

`ifdef DEMUX1TO4_COUNT_EN
    logic [7:0]         o_count_A, o_count_B, o_count_C, o_count_D;
`endif

    // The demux itself.
    modport slave (
`ifdef DEMUX1TO4_COUNT_EN
        output o_count_A, o_count_B, o_count_C, o_count_D,
`endif
        input  i_data, i_sel, i_valid,
        output o_ready,
        output o_data_A, o_data_B, o_data_C, o_data_D,
        output o_valid_A, o_valid_B, o_valid_C, o_valid_D,
        input  i_ready_A, i_ready_B, i_ready_C, i_ready_D
    );

    // Producer plus the four consumers.
    modport master (
`ifdef DEMUX1TO4_COUNT_EN
        input  o_count_A, o_count_B, o_count_C, o_count_D,
`endif
        output i_data, i_sel, i_valid,
        input  o_ready,
        input  o_data_A, o_data_B, o_data_C, o_data_D,
        input  o_valid_A, o_valid_B, o_valid_C, o_valid_D,
        output i_ready_A, i_ready_B, i_ready_C, i_ready_D
    );
endinterface

// File: rtl/demux1to4_buf.sv
// 1:4 demux steering each input word by i_sel into a one-entry per-channel output register.
// Latency: 1 cycle accept-to-output; backpressure: o_ready follows only the addressed channel.
// Optional DEMUX1TO4_COUNT_EN: 8-bit wrapping drain counters per channel.
module demux1to4_buf #(
    parameter int NB_DATA = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    demux1to4_buf_if.slave    bus
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_t;

    ch_state_t          r_state [4];
    logic [NB_DATA-1:0] r_buf   [4];

    logic [3:0] w_out_rdy;
    logic [3:0] w_full;
    logic [3:0] w_drain;
    logic [3:0] w_load;
    logic       w_in_rdy;
    logic       w_accept;

    assign w_out_rdy = {bus.i_ready_D, bus.i_ready_C, bus.i_ready_B, bus.i_ready_A};

    // A full channel still takes a word in the same cycle it drains.
    assign w_in_rdy  = !w_full[bus.i_sel] || w_out_rdy[bus.i_sel];
    assign w_accept  = bus.i_valid && w_in_rdy;
    assign w_drain   = w_full & w_out_rdy;

    assign bus.o_ready = w_in_rdy;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_ch
            assign w_full[g] = (r_state[g] == ST_FULL);
            assign w_load[g] = w_accept && (bus.i_sel == 2'(g));

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_state[g] <= ST_EMPTY;
                    r_buf[g]   <= '0;
                end else if (w_load[g]) begin
                    r_state[g] <= ST_FULL;
                    r_buf[g]   <= bus.i_data;
                end else if (w_drain[g]) begin
                    r_state[g] <= ST_EMPTY;
                end
            end
        end
    endgenerate

    assign bus.o_valid_A = w_full[0];
    assign bus.o_valid_B = w_full[1];
    assign bus.o_valid_C = w_full[2];
    assign bus.o_valid_D = w_full[3];
    assign bus.o_data_A  = r_buf[0];
    assign bus.o_data_B  = r_buf[1];
    assign bus.o_data_C  = r_buf[2];
    assign bus.o_data_D  = r_buf[3];

`ifdef DEMUX1TO4_COUNT_EN
    logic [7:0] r_count [4];

    generate
        for (g = 0; g < 4; g++) begin : g_cnt
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_count[g] <= '0;
                end else if (w_drain[g]) begin
                    r_count[g] <= r_count[g] + 8'd1;
                end
            end
        end
    endgenerate

    assign bus.o_count_A = r_count[0];
    assign bus.o_count_B = r_count[1];
    assign bus.o_count_C = r_count[2];
    assign bus.o_count_D = r_count[3];
`endif

endmodule

// File: tb/tb_demux1to4_buf.sv
// Bench for demux1to4_buf: directed steps then random traffic, scored against per-channel queues.
module tb_demux1to4_buf;
    localparam int NB = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    demux1to4_buf_if #(.NB_DATA(NB)) bus ();

    demux1to4_buf #(.NB_DATA(NB)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    // Reference: words in flight per channel, last word loaded, drain counts.
    logic [NB-1:0] sb [4][$];
    logic [NB-1:0] lastd [4];
    int            cnt [4];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic valid_of(input int ch);
        case (ch)
            0: return bus.o_valid_A;
            1: return bus.o_valid_B;
            2: return bus.o_valid_C;
            default: return bus.o_valid_D;
        endcase
    endfunction

    function automatic logic [NB-1:0] data_of(input int ch);
        case (ch)
            0: return bus.o_data_A;
            1: return bus.o_data_B;
            2: return bus.o_data_C;
            default: return bus.o_data_D;
        endcase
    endfunction

`ifdef DEMUX1TO4_COUNT_EN
    function automatic logic [7:0] count_of(input int ch);
        case (ch)
            0: return bus.o_count_A;
            1: return bus.o_count_B;
            2: return bus.o_count_C;
            default: return bus.o_count_D;
        endcase
    endfunction
`endif

    function automatic logic rdy_of(input int ch);
        case (ch)
            0: return bus.i_ready_A;
            1: return bus.i_ready_B;
            2: return bus.i_ready_C;
            default: return bus.i_ready_D;
        endcase
    endfunction

    task automatic set_in(input logic v, input logic [1:0] s, input logic [NB-1:0] d, input logic [3:0] r);
        bus.i_valid   = v;
        bus.i_sel     = s;
        bus.i_data    = d;
        bus.i_ready_A = r[0];
        bus.i_ready_B = r[1];
        bus.i_ready_C = r[2];
        bus.i_ready_D = r[3];
    endtask

    // Check outputs mid-cycle against the reference, then advance the reference across the edge.
    task automatic cycle();
        int  s;
        logic exp_rdy;
        @(negedge clk);
        if (rst_n) begin
            s = int'(bus.i_sel);
            exp_rdy = (sb[s].size() == 0) || rdy_of(s);
            for (int ch = 0; ch < 4; ch++) begin
                chk($sformatf("valid[%0d]", ch), NB'(valid_of(ch)), NB'(sb[ch].size() != 0));
                chk($sformatf("data[%0d]", ch), data_of(ch), (sb[ch].size() != 0) ? sb[ch][0] : lastd[ch]);
`ifdef DEMUX1TO4_COUNT_EN
                chk($sformatf("count[%0d]", ch), NB'(count_of(ch)), NB'(cnt[ch] % 256));
`endif
            end
            chk("o_ready", NB'(bus.o_ready), NB'(exp_rdy));
            for (int ch = 0; ch < 4; ch++) begin
                if (sb[ch].size() != 0 && rdy_of(ch)) begin
                    void'(sb[ch].pop_front());
                    cnt[ch] = cnt[ch] + 1;
                end
            end
            if (bus.i_valid && exp_rdy) begin
                sb[s].push_back(bus.i_data);
                lastd[s] = bus.i_data;
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                sb[ch].delete();
                lastd[ch] = '0;
                cnt[ch] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d_before;
        for (int ch = 0; ch < 4; ch++) begin
            lastd[ch] = '0;
            cnt[ch] = 0;
        end

        // Reset then idle
        rst_n = 1'b0;
        set_in(1'b0, 2'd0, '0, 4'hF);
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            bus.i_sel = 2'(s);
            #1;
            chk($sformatf("rst_ready[%0d]", s), NB'(bus.o_ready), NB'(1));
            chk($sformatf("rst_valid[%0d]", s), NB'(valid_of(s)), NB'(0));
            chk($sformatf("rst_data[%0d]", s), data_of(s), '0);
        end
        cycle();

        // Basic routing, one word per channel back-to-back
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 2'(i), 32'h11111111 * (i + 1), 4'hF);
            cycle();
            chk($sformatf("route_valid[%0d]", i), NB'(valid_of(i)), NB'(1));
            chk($sformatf("route_data[%0d]", i), data_of(i), 32'h11111111 * (i + 1));
        end
        set_in(1'b0, 2'd0, '0, 4'hF);
        cycle();
        cycle();

        // Stall on B
        set_in(1'b1, 2'd1, 32'hAAAA0001, 4'b1101);
        cycle();
        set_in(1'b1, 2'd1, 32'hAAAA0002, 4'b1101);
        #1;
        chk("stall_ready", NB'(bus.o_ready), NB'(0));
        cycle();
        cycle();
        chk("stall_hold", bus.o_data_B, 32'hAAAA0001);
        set_in(1'b1, 2'd1, 32'hAAAA0002, 4'hF);
        #1;
        chk("unstall_ready", NB'(bus.o_ready), NB'(1));
        cycle();
        set_in(1'b0, 2'd0, '0, 4'hF);
        chk("refill_data", bus.o_data_B, 32'hAAAA0002);
        chk("refill_valid", NB'(bus.o_valid_B), NB'(1));
        cycle();

        // Channel independence with C stalled full
        set_in(1'b1, 2'd2, 32'h7, 4'b1011);
        cycle();
        set_in(1'b1, 2'd0, 32'h5, 4'b1011);
        cycle();
        set_in(1'b1, 2'd3, 32'h6, 4'b1011);
        cycle();
        set_in(1'b0, 2'd0, '0, 4'b1011);
        chk("indep_c_valid", NB'(bus.o_valid_C), NB'(1));
        chk("indep_c_data", bus.o_data_C, 32'h7);
        cycle();
        set_in(1'b0, 2'd0, '0, 4'hF);
        cycle();

        // Full throughput on D
        d_before = cnt[3];
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 2'd3, 32'hD0000000 + i, 4'hF);
            cycle();
            chk($sformatf("thru_data[%0d]", i), bus.o_data_D, 32'hD0000000 + i);
        end
        set_in(1'b0, 2'd0, '0, 4'hF);
        cycle();
        cycle();
        chk("thru_drains", NB'(cnt[3] - d_before), NB'(8));
`ifdef DEMUX1TO4_COUNT_EN
        chk("thru_count_d", NB'(bus.o_count_D), NB'((d_before + 8) % 256));
`endif

        // Reset with A and C full and stalled
        set_in(1'b1, 2'd0, 32'hA5A5A5A5, 4'b1010);
        cycle();
        set_in(1'b1, 2'd2, 32'hC3C3C3C3, 4'b1010);
        cycle();
        set_in(1'b0, 2'd0, '0, 4'b1010);
        chk("pre_rst_a", NB'(bus.o_valid_A), NB'(1));
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            chk($sformatf("midrst_valid[%0d]", ch), NB'(valid_of(ch)), NB'(0));
`ifdef DEMUX1TO4_COUNT_EN
            chk($sformatf("midrst_count[%0d]", ch), NB'(count_of(ch)), NB'(0));
`endif
        end
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_in(1'(($urandom_range(0, 3) != 0)), 2'($urandom_range(0, 3)),
                   NB'($urandom), 4'($urandom_range(0, 15) | ($urandom_range(0, 1) ? 4'hF : 4'h0)));
            cycle();
        end
        rst_n = 1'b1;
        set_in(1'b0, 2'd0, '0, 4'hF);
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
